// File: rtl/snake_dir_ctrl.sv
// Per-player snake direction controller: button sync + debounce, priority select,
// validated turn queue, and tick-driven commit of queued turns.
module snake_dir_ctrl #(
  parameter int          PLAYERS   = 2,
  parameter int          DB_CYCLES = 50000,
  parameter int          QDEPTH    = 2,
  parameter logic [1:0]  INIT_DIR  = 2'b11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PLAYERS-1:0]     btn_up_n,
  input  logic [PLAYERS-1:0]     btn_down_n,
  input  logic [PLAYERS-1:0]     btn_left_n,
  input  logic [PLAYERS-1:0]     btn_right_n,
  input  logic                   tick,
  input  logic                   restart,
  output logic [2*PLAYERS-1:0]   direction,
  output logic [PLAYERS-1:0]     turn_applied,
  output logic [PLAYERS-1:0]     turn_dropped
);

  localparam int NB = 4 * PLAYERS;
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int QW = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  // Button index b = k*PLAYERS + i, where k is also the direction code (up, down, left, right)
  logic [NB-1:0] pins;
  logic [NB-1:0] sync_p0, sync_p1;
  logic [NB-1:0] db_stable, press_p2;
  logic [CW-1:0] db_cnt [NB];

  assign pins = {btn_right_n, btn_left_n, btn_down_n, btn_up_n};

  // Stage p0/p1: two-flop synchroniser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
    end else begin
      sync_p0 <= pins;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: debounce; a press is a stable 1->0 flip
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_stable <= '1;
      press_p2  <= '0;
      for (int b = 0; b < NB; b++) db_cnt[b] <= '0;
    end else begin
      press_p2 <= '0;
      for (int b = 0; b < NB; b++) begin
        if (sync_p1[b] == db_stable[b]) begin
          db_cnt[b] <= '0;
        end else if (db_cnt[b] == DB_LAST) begin
          db_cnt[b]    <= '0;
          db_stable[b] <= sync_p1[b];
          press_p2[b]  <= db_stable[b];
        end else begin
          db_cnt[b] <= db_cnt[b] + CW'(1);
        end
      end
    end
  end

  logic [PLAYERS-1:0]       req_vld, req_vld_p3;
  logic [PLAYERS-1:0][1:0]  req_dir, req_dir_p3;

  always_comb begin
    req_vld = '0;
    req_dir = '0;
    for (int i = 0; i < PLAYERS; i++) begin
      for (int k = 3; k >= 0; k--) begin
        if (press_p2[k*PLAYERS + i]) begin
          req_vld[i] = 1'b1;
          req_dir[i] = 2'(k);
        end
      end
    end
  end

  // Stage p3: one winning request per player
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_vld_p3 <= '0;
      req_dir_p3 <= '0;
    end else begin
      req_vld_p3 <= req_vld;
      req_dir_p3 <= req_dir;
    end
  end

  logic [PLAYERS-1:0][QDEPTH-1:0][1:0] q, q_nx;
  logic [PLAYERS-1:0][QW-1:0]          qcnt, qcnt_nx;
  logic [PLAYERS-1:0][1:0]             dir_r, dir_nx;
  logic [PLAYERS-1:0]                  app_nx, drp_nx;

  // Validation sees the pre-tick state; pop happens before push so a full queue can accept on a tick
  always_comb begin
    logic [1:0]    ref_dir;
    logic          pop;
    logic          accept;
    logic [QW-1:0] base;
    q_nx    = q;
    qcnt_nx = qcnt;
    dir_nx  = dir_r;
    app_nx  = '0;
    drp_nx  = '0;
    ref_dir = '0;
    pop     = 1'b0;
    accept  = 1'b0;
    base    = '0;
    for (int i = 0; i < PLAYERS; i++) begin
      ref_dir = dir_r[i];
      for (int j = 0; j < QDEPTH; j++) begin
        if (qcnt[i] == QW'(j + 1)) ref_dir = q[i][j];
      end
      pop    = tick && (qcnt[i] != '0);
      accept = req_vld_p3[i] && (req_dir_p3[i] != ref_dir)
            && (req_dir_p3[i] != {ref_dir[1], ~ref_dir[0]})
            && ((qcnt[i] != QW'(QDEPTH)) || pop);
      base   = qcnt[i] - QW'(pop);
      if (pop) begin
        dir_nx[i] = q[i][0];
        app_nx[i] = 1'b1;
        for (int j = 0; j < QDEPTH - 1; j++) q_nx[i][j] = q[i][j+1];
      end
      if (accept) begin
        for (int j = 0; j < QDEPTH; j++) begin
          if (base == QW'(j)) q_nx[i][j] = req_dir_p3[i];
        end
      end
      qcnt_nx[i] = base + QW'(accept);
      drp_nx[i]  = req_vld_p3[i] && !accept;
    end
    if (restart) begin
      qcnt_nx = '0;
      dir_nx  = {PLAYERS{INIT_DIR}};
      app_nx  = '0;
      drp_nx  = '0;
    end
  end

  // Stage p4: committed direction, queues and event pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q            <= '0;
      qcnt         <= '0;
      dir_r        <= {PLAYERS{INIT_DIR}};
      turn_applied <= '0;
      turn_dropped <= '0;
    end else begin
      q            <= q_nx;
      qcnt         <= qcnt_nx;
      dir_r        <= dir_nx;
      turn_applied <= app_nx;
      turn_dropped <= drp_nx;
    end
  end

  assign direction = dir_r;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Scoreboard bench for snake_dir_ctrl: a queue-based player model predicts
// apply/drop events; a negedge monitor pops and compares them against the DUT.
module tb_snake_dir_ctrl;
  localparam int         P    = 2;
  localparam int         DB   = 4;
  localparam int         QD   = 2;
  localparam logic [1:0] INIT = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       restart = 1'b0;
  logic [1:0] bu = '1, bd = '1, bl = '1, br = '1;
  logic [3:0] direction;
  logic [1:0] turn_applied, turn_dropped;

  snake_dir_ctrl #(.PLAYERS(P), .DB_CYCLES(DB), .QDEPTH(QD), .INIT_DIR(INIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_up_n(bu), .btn_down_n(bd), .btn_left_n(bl), .btn_right_n(br),
    .tick(tick), .restart(restart),
    .direction(direction), .turn_applied(turn_applied), .turn_dropped(turn_dropped)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nfail = 0;

  typedef struct {bit drop; logic [1:0] dir;} ev_t;
  ev_t        expq [P][$];
  logic [1:0] mdir [P];
  logic [1:0] mq   [P][$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mon_event(input int i, input bit drop);
    ev_t e;
    if (expq[i].size() == 0) begin
      nvec++;
      nfail++;
      $display("FAIL unexpected_%s_p%0d: pulse seen, none expected", drop ? "drop" : "apply", i);
    end else begin
      e = expq[i].pop_front();
      check($sformatf("event_kind_p%0d", i), 32'(drop), 32'(e.drop));
      check($sformatf("event_dir_p%0d", i), 32'(direction[2*i +: 2]), 32'(e.dir));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < P; i++) begin
        if (turn_applied[i]) mon_event(i, 1'b0);
        if (turn_dropped[i]) mon_event(i, 1'b1);
      end
    end
  end

  // Reference: per-player list of pending turns plus committed heading
  task automatic model_step(input bit tk, input int p, input logic [3:0] mask);
    for (int i = 0; i < P; i++) begin
      logic [1:0] r;
      int         len;
      int         d;
      bit         app, drp, acc;
      len = mq[i].size();
      r   = (len > 0) ? mq[i][len-1] : mdir[i];
      app = tk && (len > 0);
      drp = 1'b0;
      if (app) mdir[i] = mq[i].pop_front();
      if (i == p && mask != 4'b0) begin
        d = 0;
        while (!mask[d]) d++;
        acc = (2'(d) != r) && (2'(d) != (r ^ 2'b01)) && ((len < QD) || app);
        if (acc) mq[i].push_back(2'(d));
        else drp = 1'b1;
      end
      if (app) expq[i].push_back('{1'b0, mdir[i]});
      if (drp) expq[i].push_back('{1'b1, mdir[i]});
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < P; i++) begin
      mdir[i] = INIT;
      mq[i].delete();
      expq[i].delete();
    end
  endtask

  task automatic check_dir(input string name);
    check(name, 32'(direction), 32'({mdir[1], mdir[0]}));
  endtask

  task automatic set_pins(input int p, input logic [3:0] mask, input bit low);
    if (mask[0]) bu[p] = !low;
    if (mask[1]) bd[p] = !low;
    if (mask[2]) bl[p] = !low;
    if (mask[3]) br[p] = !low;
  endtask

  // Pins go low before edge E; the request is judged at edge E+7, where tk optionally coincides
  task automatic do_press(input int p, input logic [3:0] mask, input bit tk);
    @(negedge clk);
    set_pins(p, mask, 1'b1);
    repeat (7) @(negedge clk);
    tick = tk;
    model_step(tk, p, mask);
    @(negedge clk);
    tick = 1'b0;
    repeat (2) @(negedge clk);
    set_pins(p, mask, 1'b0);
    repeat (10) @(negedge clk);
    check_dir("dir_after_press");
  endtask

  task automatic do_tick();
    @(negedge clk);
    tick = 1'b1;
    model_step(1'b1, -1, 4'b0);
    @(negedge clk);
    tick = 1'b0;
    check_dir("dir_after_tick");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_direction", 32'(direction), 32'h f);
    check("reset_applied", 32'(turn_applied), 32'h0);
    check("reset_dropped", 32'(turn_dropped), 32'h0);
    rst_n = 1'b1;

    // Short glitch must not register
    @(negedge clk);
    bu[0] = 1'b0;
    repeat (3) @(negedge clk);
    bu[0] = 1'b1;
    repeat (12) @(negedge clk);
    check_dir("glitch_dir");
    do_tick();

    // Basic turn on player 0
    do_press(0, 4'b0001, 1'b0);
    do_tick();
    check("basic_dir", 32'(direction), 32'h c);

    // No-op and reversal on player 1
    do_press(1, 4'b0100, 1'b0);
    do_press(1, 4'b1000, 1'b0);

    // Buffered double turn, third press overflows
    do_press(1, 4'b0001, 1'b0);
    do_press(1, 4'b0100, 1'b0);
    do_press(1, 4'b0010, 1'b0);
    do_tick();
    check("double_tick1", 32'(direction[3:2]), 32'h0);
    do_tick();
    check("double_tick2", 32'(direction[3:2]), 32'h2);

    // Simultaneous up+left: up wins
    do_press(1, 4'b0101, 1'b0);
    do_tick();
    check("prio_dir", 32'(direction[3:2]), 32'h0);

    // Press coinciding with tick on empty queue
    do_press(0, 4'b0100, 1'b1);
    check("coincide_hold", 32'(direction[1:0]), 32'h0);
    do_tick();
    check("coincide_commit", 32'(direction[1:0]), 32'h2);

    // Restart together with tick while both queues hold entries
    do_press(0, 4'b0001, 1'b0);
    do_press(1, 4'b1000, 1'b0);
    @(negedge clk);
    restart = 1'b1;
    tick = 1'b1;
    for (int i = 0; i < P; i++) begin
      mdir[i] = INIT;
      mq[i].delete();
    end
    @(negedge clk);
    restart = 1'b0;
    tick = 1'b0;
    check("restart_dir", 32'(direction), 32'h f);
    do_tick();

    // Randomised traffic
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) != 0)
        do_press(int'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), $urandom_range(0, 3) == 0);
      else
        do_tick();
    end

    // Asynchronous reset in the middle of a debounce
    @(negedge clk);
    restart = 1'b1;
    model_reset();
    @(negedge clk);
    restart = 1'b0;
    do_press(0, 4'b0001, 1'b0);
    do_tick();
    @(negedge clk);
    bd[1] = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_dir", 32'(direction), 32'h f);
    check("async_rst_applied", 32'(turn_applied), 32'h0);
    check("async_rst_dropped", 32'(turn_dropped), 32'h0);
    model_reset();
    bd[1] = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check_dir("post_reset_dir");
    do_press(1, 4'b0001, 1'b0);
    do_tick();

    repeat (4) @(negedge clk);
    for (int i = 0; i < P; i++)
      check($sformatf("pending_events_p%0d", i), 32'(expq[i].size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
